uart_rx_fifo: RTL and testbench

Serial receive front end for the IO path: samples an asynchronous 8N1 UART line, assembles bytes and buffers them in a small FIFO. Its output is a byte valid/ready stream that connects directly to the IO controller's input side (`io_in_data` / `io_in_vld` / `io_in_rdy`), so host-supplied bytes reach the core through the existing IO handshake. Line errors are reported as sticky flags that feed the IO error vector.

---
 rtl/io_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_rx_fifo.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared types and constants for the IO path serial receive front end.
//   rx_state_t     : UART receiver FSM states
//   ERR_FRAME      : bit index of the framing-error flag in the error vector
//   ERR_OVF        : bit index of the FIFO-overflow flag in the error vector
//   UART_DATA_BITS : data bits per UART character (8N1 framing)
// -----------------------------------------------------------------------------
package io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int ERR_FRAME      = 0;
    localparam int ERR_OVF        = 1;
    localparam int UART_DATA_BITS = 8;

endpackage : io_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with free-running wrap-around pointers and an explicit
// occupancy counter. Storage is not reset; the head word is read straight
// from the array at the read pointer, so rd_data depends only on registers.
//   clk, rstn   : clock, asynchronous active-low reset
//   push        : write push_data this cycle (ignored when full unless pop)
//   push_data   : WIDTH-bit write word
//   pop         : remove the head word this cycle (ignored when empty)
//   rd_data     : word at the head of the FIFO
//   level       : current occupancy, 0..DEPTH
//   full, empty : occupancy status
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full    = (level_r == LW'(DEPTH));
    assign empty   = (level_r == LW'(0));
    assign rd_en_s = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en_s = push && (!full || rd_en_s);
    assign rd_data = mem_r[rd_ptr_r];
    assign level   = level_r;

    // Storage array write port (intentionally without reset).
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 UART receiver feeding a byte FIFO whose output is a valid/ready stream.
// Line errors are kept as sticky flags.
//   clk, rstn : clock, asynchronous active-low reset
//   rxd       : asynchronous UART line, idle high
//   out_data  : byte at FIFO head
//   out_vld   : FIFO non-empty
//   out_rdy   : consumer accepts head byte
//   level     : FIFO occupancy
//   err       : sticky flags, [0] framing error, [1] overflow
//   err_clr   : clears both err bits (a same-cycle set wins)
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import io_pkg::*;
#(
    parameter int CLK_PER_BIT = 8,
    parameter int DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rxd,
    output logic [7:0]               out_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [1:0]               err,
    input  logic                     err_clr
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                       sync1_r;
    logic                       rxs_r;
    logic                       rxs_d_r;
    rx_state_t                  state_r;
    logic [CNT_W-1:0]           cnt_r;
    logic [2:0]                 bit_idx_r;
    logic [UART_DATA_BITS-1:0]  shift_r;
    logic [1:0]                 err_r;

    logic                       stop_smp_s;
    logic                       push_req_s;
    logic                       frame_err_s;
    logic                       pop_s;
    logic                       fifo_push_s;
    logic                       ovf_s;
    logic                       full_s;
    logic                       empty_s;

    // Two-flop synchronizer for rxd plus one delayed copy for falling-edge detect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
            rxs_d_r <= 1'b1;
        end else begin
            sync1_r <= rxd;
            rxs_r   <= sync1_r;
            rxs_d_r <= rxs_r;
        end
    end

    // Receiver FSM: mid-bit sampling driven by a down-counting baud counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_W'(0);
            bit_idx_r <= 3'd0;
            shift_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Only a fresh falling edge arms the receiver, so a line
                    // held low after a bad stop bit does not retrigger.
                    if (rxs_d_r && !rxs_r) begin
                        state_r <= ST_START;
                        cnt_r   <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_W'(0)) begin
                        if (rxs_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                            cnt_r     <= FULL_LOAD;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_W'(0)) begin
                        shift_r <= {rxs_r, shift_r[UART_DATA_BITS-1:1]};
                        cnt_r   <= FULL_LOAD;
                        if (bit_idx_r == LAST_BIT) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == CNT_W'(0)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_W'(0);
                end
            endcase
        end
    end

    assign stop_smp_s  = (state_r == ST_STOP) && (cnt_r == CNT_W'(0));
    assign push_req_s  = stop_smp_s && rxs_r;
    assign frame_err_s = stop_smp_s && !rxs_r;
    assign pop_s       = !empty_s && out_rdy;
    assign fifo_push_s = push_req_s && (!full_s || pop_s);
    assign ovf_s       = push_req_s && full_s && !pop_s;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push_s),
        .push_data (shift_r),
        .pop       (pop_s),
        .rd_data   (out_data),
        .level     (level),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Sticky error flags; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_r <= 2'b00;
        end else begin
            if (frame_err_s) begin
                err_r[ERR_FRAME] <= 1'b1;
            end else if (err_clr) begin
                err_r[ERR_FRAME] <= 1'b0;
            end else begin
                err_r[ERR_FRAME] <= err_r[ERR_FRAME];
            end
            if (ovf_s) begin
                err_r[ERR_OVF] <= 1'b1;
            end else if (err_clr) begin
                err_r[ERR_OVF] <= 1'b0;
            end else begin
                err_r[ERR_OVF] <= err_r[ERR_OVF];
            end
        end
    end

    assign out_vld = !empty_s;
    assign err     = err_r;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed self-checking bench for uart_rx_fifo (CLK_PER_BIT=8, DEPTH=16).
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rxd;
    logic [7:0] out_data;
    logic       out_vld;
    logic       out_rdy;
    logic [4:0] level;
    logic [1:0] err;
    logic       err_clr;

    int checks = 0;
    int errors = 0;
    int first_vld_k;

    uart_rx_fifo #(
        .CLK_PER_BIT (CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .level    (level),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    // Drive one 8N1 frame, one bit per CPB cycles, for ncyc cycles (80 = whole
    // frame). k counts rising edges from the start-bit edge; first_vld_k is the
    // first k at which out_vld was seen high. With pulse set, out_rdy is high
    // only for the edge on which the stop bit is sampled (k=79).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit pulse, input int ncyc);
        first_vld_k = -1;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            if (out_vld && first_vld_k < 0) first_vld_k = k;
            if (k < 8)       rxd = 1'b0;
            else if (k < 72) rxd = b[(k - 8) / 8];
            else             rxd = stop_bit;
            if (pulse) out_rdy = (k == 78);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; rxd = 1'b1; out_rdy = 1'b0; err_clr = 1'b0;
        idle_cycles(3);
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", out_vld); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
        rstn = 1'b1;
        idle_cycles(5);
        checks++; if (out_vld !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL post_reset_idle: vld %b level %0d expected 0/0", out_vld, level); end
    endtask

    task automatic test_single;
        out_rdy = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 80);
        checks++; if (first_vld_k !== 79) begin errors++; $display("FAIL single_latency: got %0d expected 79", first_vld_k); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", out_data); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL single_err: got %b expected 00", err); end
        idle_cycles(1);
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL single_vld_width: got %b expected 0", out_vld); end
        out_rdy = 1'b0;
        idle_cycles(4);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_frame(exp_b[i], 1'b1, 1'b0, 80);
            checks++; if (level !== 5'(i + 1)) begin errors++; $display("FAIL b2b_level%0d: got %0d expected %0d", i, level, i + 1); end
        end
        rxd = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_vld !== 1'b1 || out_data !== exp_b[i]) begin errors++; $display("FAIL b2b_pop%0d: vld %b data %h expected 1/%h", i, out_vld, out_data, exp_b[i]); end
            idle_cycles(1);
        end
        out_rdy = 1'b0;
        checks++; if (level !== 5'd0 || out_vld !== 1'b0) begin errors++; $display("FAIL b2b_drained: level %0d vld %b expected 0/0", level, out_vld); end
        idle_cycles(4);
    endtask

    task automatic test_glitch;
        @(posedge clk); #1; rxd = 1'b0;
        idle_cycles(3);
        rxd = 1'b1;
        idle_cycles(20);
        checks++; if (level !== 5'd0 || out_vld !== 1'b0) begin errors++; $display("FAIL glitch_push: level %0d vld %b expected 0/0", level, out_vld); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL glitch_err: got %b expected 00", err); end
        send_frame(8'h55, 1'b1, 1'b0, 80);
        checks++; if (first_vld_k !== 79 || out_data !== 8'h55) begin errors++; $display("FAIL glitch_next: k %0d data %h expected 79/55", first_vld_k, out_data); end
        out_rdy = 1'b1; idle_cycles(1); out_rdy = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL glitch_drain: got %0d expected 0", level); end
        idle_cycles(4);
    endtask

    task automatic test_framing;
        send_frame(8'h81, 1'b0, 1'b0, 80);
        idle_cycles(1);
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL frame_err: got %b expected 01", err); end
        checks++; if (level !== 5'd0 || out_vld !== 1'b0) begin errors++; $display("FAIL frame_nopush: level %0d vld %b expected 0/0", level, out_vld); end
        // Line held low as a break: must not produce another frame.
        idle_cycles(100);
        rxd = 1'b1;
        idle_cycles(5);
        checks++; if (err !== 2'b01 || level !== 5'd0) begin errors++; $display("FAIL frame_sticky: err %b level %0d expected 01/0", err, level); end
        err_clr = 1'b1; idle_cycles(1); err_clr = 1'b0;
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL frame_clr: got %b expected 00", err); end
        idle_cycles(4);
    endtask

    task automatic test_overflow;
        out_rdy = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 80);
            if (i == 16) begin
                checks++; if (level !== 5'd16 || err !== 2'b00) begin errors++; $display("FAIL ovf_fill: level %0d err %b expected 16/00", level, err); end
            end
        end
        idle_cycles(1);
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL ovf_err: got %b expected 10", err); end
        out_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            checks++; if (out_vld !== 1'b1 || out_data !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d: vld %b data %h expected 1/%h", i, out_vld, out_data, 8'(i)); end
            idle_cycles(1);
        end
        out_rdy = 1'b0;
        checks++; if (level !== 5'd0 || err !== 2'b10) begin errors++; $display("FAIL ovf_after_drain: level %0d err %b expected 0/10", level, err); end
        err_clr = 1'b1; idle_cycles(1); err_clr = 1'b0;
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL ovf_clr: got %b expected 00", err); end

        // Same fill, but the head is popped on the edge of the 17th push.
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 1'b1, (i == 17), 80);
        end
        idle_cycles(1);
        checks++; if (level !== 5'd16 || err !== 2'b00) begin errors++; $display("FAIL ovf_popsame: level %0d err %b expected 16/00", level, err); end
        out_rdy = 1'b1;
        for (int i = 2; i <= 17; i++) begin
            checks++; if (out_vld !== 1'b1 || out_data !== 8'(i)) begin errors++; $display("FAIL ovf2_drain%0d: vld %b data %h expected 1/%h", i, out_vld, out_data, 8'(i)); end
            idle_cycles(1);
        end
        out_rdy = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovf2_empty: got %0d expected 0", level); end
        idle_cycles(4);
    endtask

    task automatic test_reset_midframe;
        out_rdy = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, 80);
        rxd = 1'b1;
        idle_cycles(4);
        send_frame(8'h11, 1'b1, 1'b0, 80);
        send_frame(8'h22, 1'b1, 1'b0, 80);
        send_frame(8'h33, 1'b1, 1'b0, 80);
        checks++; if (level !== 5'd3 || err !== 2'b01) begin errors++; $display("FAIL rst_pre: level %0d err %b expected 3/01", level, err); end
        // Stop inside data bit 4 (bits 0..3 = 0 for 0xE0, bit 4 = 0... use 0x99).
        send_frame(8'h99, 1'b1, 1'b0, 44);
        #2 rstn = 1'b0;
        #1;
        checks++; if (out_vld !== 1'b0 || level !== 5'd0 || err !== 2'b00) begin errors++; $display("FAIL rst_mid: vld %b level %0d err %b expected 0/0/00", out_vld, level, err); end
        rxd = 1'b1;
        @(posedge clk); #1 rstn = 1'b1;
        idle_cycles(CPB * 12);
        checks++; if (level !== 5'd0 || err !== 2'b00) begin errors++; $display("FAIL rst_quiet: level %0d err %b expected 0/00", level, err); end
        send_frame(8'h42, 1'b1, 1'b0, 80);
        checks++; if (first_vld_k !== 79 || out_data !== 8'h42 || level !== 5'd1) begin errors++; $display("FAIL rst_next: k %0d data %h level %0d expected 79/42/1", first_vld_k, out_data, level); end
        rxd = 1'b1;
        idle_cycles(4);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overflow();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_rx_fifo
